// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: reset PC, credit depth and the
// {pc, instr} packet carried from fetch into the instruction queue.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC        = 32'h1eceb000;
    localparam int          MAX_OUTSTANDING = 4;
    localparam int          IQ_WIDTH        = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_pkt_t;

    function automatic logic [31:0] next_word(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Small circular FIFO of fetch packets with flush and same-cycle push/pop.
// Storage is not reset; the head is only meaningful while count != 0.
module fetch_skid_buf
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = MAX_OUTSTANDING,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  fetch_pkt_t       push_pkt,
    input  logic             pop,
    output fetch_pkt_t       head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    fetch_pkt_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign push_ok = push && ((count != CNT_W'(DEPTH)) || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_pkt;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited pipelined imem reads,
// in-order response capture, redirect with squash of old-path responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = fetch_unit_pkg::RESET_PC,
    parameter int          MAX_OUTSTANDING = fetch_unit_pkg::MAX_OUTSTANDING,
    parameter int          IQ_WIDTH        = fetch_unit_pkg::IQ_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    output logic [31:0]         imem_addr,
    output logic [3:0]          imem_rmask,
    input  logic [31:0]         imem_rdata,
    input  logic                imem_resp,
    output logic [IQ_WIDTH-1:0] iq_wdata,
    output logic                iq_enqueue,
    input  logic                iq_full,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc
);

    import fetch_unit_pkg::*;

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    typedef logic [CNT_W-1:0] cnt_t;

    logic [31:0] pc;
    logic [31:0] resp_pc;
    cnt_t        outstanding;
    cnt_t        squash_cnt;
    cnt_t        buf_count;
    logic [CNT_W:0] credits_used;
    logic        buf_empty;
    logic        can_issue;
    logic        keep_resp;
    fetch_pkt_t  head;
    fetch_pkt_t  resp_pkt;

    // Credits cover both in-flight reads and parked responses, so the
    // buffer can never overflow however long the queue stays full.
    assign credits_used = {1'b0, outstanding} + {1'b0, buf_count};
    assign can_issue    = !rst && !redirect_valid
                        && (credits_used < (CNT_W+1)'(MAX_OUTSTANDING));

    assign imem_rmask = can_issue ? 4'hF : 4'h0;
    assign imem_addr  = pc;

    assign keep_resp  = imem_resp && !redirect_valid && (squash_cnt == '0);
    assign resp_pkt   = '{pc: resp_pc, instr: imem_rdata};

    assign iq_enqueue = !rst && !buf_empty && !iq_full && !redirect_valid;
    assign iq_wdata   = buf_empty ? '0 : IQ_WIDTH'(head);

    fetch_skid_buf #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (keep_resp),
        .push_pkt (resp_pkt),
        .pop      (iq_enqueue),
        .head     (head),
        .count    (buf_count),
        .empty    (buf_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            squash_cnt  <= '0;
        end else begin
            outstanding <= outstanding + cnt_t'(can_issue) - cnt_t'(imem_resp);
            if (redirect_valid) begin
                pc         <= redirect_pc;
                resp_pc    <= redirect_pc;
                // Everything still in flight after this cycle is old-path.
                squash_cnt <= outstanding - cnt_t'(imem_resp);
            end else begin
                if (can_issue) pc <= next_word(pc);
                if (keep_resp) resp_pc <= next_word(resp_pc);
                if (imem_resp && (squash_cnt != '0))
                    squash_cnt <= squash_cnt - cnt_t'(1);
            end
        end
    end

    a_resp_needs_req: assert property (
        @(posedge clk) disable iff (rst) imem_resp |-> (outstanding != '0));
    a_no_enq_when_full: assert property (
        @(posedge clk) disable iff (rst) iq_full |-> !iq_enqueue);
    a_buf_bound: assert property (
        @(posedge clk) disable iff (rst) buf_count <= cnt_t'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model of the
// fetch stream, latency-configurable memory model and scenario tasks.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h1eceb000;
    localparam int          MAXO   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [63:0] iq_wdata;
    logic        iq_enqueue;
    logic        iq_full;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rmask     (imem_rmask),
        .imem_rdata     (imem_rdata),
        .imem_resp      (imem_resp),
        .iq_wdata       (iq_wdata),
        .iq_enqueue     (iq_enqueue),
        .iq_full        (iq_full),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] addr; bit stale; } mdl_t;

    mreq_t       mem_q [$];
    mdl_t        mdl_q [$];
    logic [63:0] buff  [$];
    logic [31:0] mpc;
    int          cyc, last_due, lat_lo, lat_hi;
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [3:0]  o_rmask, e_rmask;
    logic [31:0] o_addr, e_addr;
    logic        o_enq, e_enq;
    logic [63:0] o_wdata, e_wdata;
    bit          e_issue;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hc3d2e1f0 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic model_clear();
        mem_q.delete();
        mdl_q.delete();
        buff.delete();
        mpc      = RST_PC;
        cyc      = 0;
        last_due = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_resp = 1'b0;
        imem_rdata = '0;
        iq_full = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        repeat (2) @(negedge clk);
        model_clear();
        rst = 1'b0;
    endtask

    // Called at a falling edge: drive one cycle, sample, advance the model.
    task automatic step(input bit full, input bit redir, input logic [31:0] rpc);
        mdl_t m;
        int   d;
        iq_full = full;
        redirect_valid = redir;
        redirect_pc = rpc;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp  = 1'b1;
            imem_rdata = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_resp  = 1'b0;
            imem_rdata = $urandom;
        end
        #1;
        o_rmask = imem_rmask;
        o_addr  = imem_addr;
        o_enq   = iq_enqueue;
        o_wdata = iq_wdata;
        e_issue = !redir && ((mdl_q.size() + buff.size()) < MAXO);
        e_rmask = e_issue ? 4'hF : 4'h0;
        e_addr  = mpc;
        e_enq   = (buff.size() > 0) && !full && !redir;
        e_wdata = (buff.size() > 0) ? buff[0] : '0;
        if (o_rmask == 4'hF) begin
            d = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mem_q.push_back('{o_addr, d});
        end
        if (e_enq) void'(buff.pop_front());
        if (imem_resp && mdl_q.size() > 0) begin
            m = mdl_q.pop_front();
            if (!m.stale && !redir) buff.push_back({m.addr, mem_word(m.addr)});
        end
        if (redir) begin
            buff.delete();
            foreach (mdl_q[i]) mdl_q[i].stale = 1'b1;
            mpc = rpc;
        end else if (e_issue) begin
            mdl_q.push_back('{mpc, 1'b0});
            mpc = mpc + 32'd4;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_resp = 1'b0;
        imem_rdata = '0;
        iq_full = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        @(negedge clk);
        #1;
        n_checks++; if (imem_rmask !== 4'h0) begin n_fail++; $display("FAIL reset_rmask got=%h exp=0", imem_rmask); end
        n_checks++; if (iq_enqueue !== 1'b0) begin n_fail++; $display("FAIL reset_enq got=%b exp=0", iq_enqueue); end
        n_checks++; if (imem_addr !== RST_PC) begin n_fail++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RST_PC); end
        n_checks++; if (iq_wdata !== 64'h0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", iq_wdata); end
        do_reset();
    endtask

    task automatic test_stream();
        int first = -1;
        int issued = 0;
        do_reset();
        lat_lo = 1; lat_hi = 1;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b0, '0);
            n_checks++; if (o_rmask !== e_rmask) begin n_fail++; $display("FAIL stream_rmask k=%0d got=%h exp=%h", k, o_rmask, e_rmask); end
            if (e_issue) begin n_checks++; if (o_addr !== e_addr) begin n_fail++; $display("FAIL stream_addr k=%0d got=%h exp=%h", k, o_addr, e_addr); end end
            n_checks++; if (o_enq !== e_enq) begin n_fail++; $display("FAIL stream_enq k=%0d got=%b exp=%b", k, o_enq, e_enq); end
            if (e_enq) begin n_checks++; if (o_wdata !== e_wdata) begin n_fail++; $display("FAIL stream_wdata k=%0d got=%h exp=%h", k, o_wdata, e_wdata); end end
            if (o_rmask == 4'hF) issued++;
            if (o_enq && first < 0) first = k;
        end
        n_checks++; if (issued !== 12) begin n_fail++; $display("FAIL stream_issue_count got=%0d exp=12", issued); end
        n_checks++; if (first !== 2) begin n_fail++; $display("FAIL stream_first_enq got=%0d exp=2", first); end
    endtask

    task automatic test_full_hold();
        int issued = 0;
        int n_enq = 0;
        logic [31:0] first_addr = '0;
        bit seen = 1'b0;
        do_reset();
        lat_lo = 3; lat_hi = 3;
        for (int k = 0; k < 24; k++) begin
            step(k < 12, 1'b0, '0);
            n_checks++; if (o_rmask !== e_rmask) begin n_fail++; $display("FAIL full_rmask k=%0d got=%h exp=%h", k, o_rmask, e_rmask); end
            if (e_issue) begin n_checks++; if (o_addr !== e_addr) begin n_fail++; $display("FAIL full_addr k=%0d got=%h exp=%h", k, o_addr, e_addr); end end
            n_checks++; if (o_enq !== e_enq) begin n_fail++; $display("FAIL full_enq k=%0d got=%b exp=%b", k, o_enq, e_enq); end
            if (e_enq) begin n_checks++; if (o_wdata !== e_wdata) begin n_fail++; $display("FAIL full_wdata k=%0d got=%h exp=%h", k, o_wdata, e_wdata); end end
            if (k < 12 && o_rmask == 4'hF) issued++;
            if (k >= 12 && o_rmask == 4'hF && !seen) begin seen = 1'b1; first_addr = o_addr; end
            if (k >= 12 && o_enq && n_enq < 4) begin
                n_checks++;
                if (o_wdata[63:32] !== RST_PC + 32'(4 * n_enq)) begin n_fail++; $display("FAIL full_drain_pc n=%0d got=%h exp=%h", n_enq, o_wdata[63:32], RST_PC + 32'(4 * n_enq)); end
                n_enq++;
            end
        end
        n_checks++; if (issued !== 4) begin n_fail++; $display("FAIL full_issue_count got=%0d exp=4", issued); end
        n_checks++; if (first_addr !== 32'h1eceb010) begin n_fail++; $display("FAIL full_resume_addr got=%h exp=1eceb010", first_addr); end
        n_checks++; if (n_enq !== 4) begin n_fail++; $display("FAIL full_drain_count got=%0d exp=4", n_enq); end
    endtask

    task automatic test_redirect();
        bit seen = 1'b0;
        logic [63:0] first = '0;
        do_reset();
        lat_lo = 4; lat_hi = 4;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, k == 3, 32'h60000000);
            n_checks++; if (o_rmask !== e_rmask) begin n_fail++; $display("FAIL redir_rmask k=%0d got=%h exp=%h", k, o_rmask, e_rmask); end
            if (e_issue) begin n_checks++; if (o_addr !== e_addr) begin n_fail++; $display("FAIL redir_addr k=%0d got=%h exp=%h", k, o_addr, e_addr); end end
            n_checks++; if (o_enq !== e_enq) begin n_fail++; $display("FAIL redir_enq k=%0d got=%b exp=%b", k, o_enq, e_enq); end
            if (e_enq) begin n_checks++; if (o_wdata !== e_wdata) begin n_fail++; $display("FAIL redir_wdata k=%0d got=%h exp=%h", k, o_wdata, e_wdata); end end
            if (o_enq && !seen) begin seen = 1'b1; first = o_wdata; end
        end
        n_checks++; if (first !== {32'h60000000, mem_word(32'h60000000)}) begin n_fail++; $display("FAIL redir_first_entry got=%h exp=%h", first, {32'h60000000, mem_word(32'h60000000)}); end
    endtask

    task automatic test_redirect_with_resp();
        int old_enq = 0;
        logic [31:0] first_pc = '0;
        bit seen = 1'b0;
        do_reset();
        lat_lo = 2; lat_hi = 2;
        for (int k = 0; k < 14; k++) begin
            step(1'b0, k == 2, 32'h00000700);
            n_checks++; if (o_rmask !== e_rmask) begin n_fail++; $display("FAIL rresp_rmask k=%0d got=%h exp=%h", k, o_rmask, e_rmask); end
            if (e_issue) begin n_checks++; if (o_addr !== e_addr) begin n_fail++; $display("FAIL rresp_addr k=%0d got=%h exp=%h", k, o_addr, e_addr); end end
            n_checks++; if (o_enq !== e_enq) begin n_fail++; $display("FAIL rresp_enq k=%0d got=%b exp=%b", k, o_enq, e_enq); end
            if (e_enq) begin n_checks++; if (o_wdata !== e_wdata) begin n_fail++; $display("FAIL rresp_wdata k=%0d got=%h exp=%h", k, o_wdata, e_wdata); end end
            if (o_enq && o_wdata[63:44] == 20'h1eceb) old_enq++;
            if (o_enq && !seen) begin seen = 1'b1; first_pc = o_wdata[63:32]; end
        end
        n_checks++; if (old_enq !== 0) begin n_fail++; $display("FAIL rresp_old_path got=%0d exp=0", old_enq); end
        n_checks++; if (first_pc !== 32'h00000700) begin n_fail++; $display("FAIL rresp_first_pc got=%h exp=00000700", first_pc); end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        logic [31:0] first_pc = '0;
        bit seen = 1'b0;
        do_reset();
        lat_lo = 3; lat_hi = 3;
        for (int k = 0; k < 16; k++) begin
            step(1'b0, k == 2 || k == 3, (k == 2) ? 32'h100 : 32'h200);
            n_checks++; if (o_rmask !== e_rmask) begin n_fail++; $display("FAIL b2b_rmask k=%0d got=%h exp=%h", k, o_rmask, e_rmask); end
            if (e_issue) begin n_checks++; if (o_addr !== e_addr) begin n_fail++; $display("FAIL b2b_addr k=%0d got=%h exp=%h", k, o_addr, e_addr); end end
            n_checks++; if (o_enq !== e_enq) begin n_fail++; $display("FAIL b2b_enq k=%0d got=%b exp=%b", k, o_enq, e_enq); end
            if (e_enq) begin n_checks++; if (o_wdata !== e_wdata) begin n_fail++; $display("FAIL b2b_wdata k=%0d got=%h exp=%h", k, o_wdata, e_wdata); end end
            if (o_enq && o_wdata[63:32] >= 32'h100 && o_wdata[63:32] < 32'h200) bad++;
            if (o_enq && !seen) begin seen = 1'b1; first_pc = o_wdata[63:32]; end
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_stale_entries got=%0d exp=0", bad); end
        n_checks++; if (first_pc !== 32'h200) begin n_fail++; $display("FAIL b2b_first_pc got=%h exp=00000200", first_pc); end
    endtask

    task automatic test_random();
        do_reset();
        lat_lo = 1; lat_hi = 5;
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(9, 0) < 3, $urandom_range(29, 0) == 0, $urandom & 32'hffff_fffc);
            n_checks++; if (o_rmask !== e_rmask) begin n_fail++; $display("FAIL rand_rmask k=%0d got=%h exp=%h", k, o_rmask, e_rmask); end
            if (e_issue) begin n_checks++; if (o_addr !== e_addr) begin n_fail++; $display("FAIL rand_addr k=%0d got=%h exp=%h", k, o_addr, e_addr); end end
            n_checks++; if (o_enq !== e_enq) begin n_fail++; $display("FAIL rand_enq k=%0d got=%b exp=%b", k, o_enq, e_enq); end
            if (e_enq) begin n_checks++; if (o_wdata !== e_wdata) begin n_fail++; $display("FAIL rand_wdata k=%0d got=%h exp=%h", k, o_wdata, e_wdata); end end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] first_addr = '0;
        do_reset();
        lat_lo = 1; lat_hi = 1;
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, '0);
        #3;
        rst = 1'b1;
        imem_resp = 1'b0;
        #1;
        n_checks++; if (imem_rmask !== 4'h0) begin n_fail++; $display("FAIL arst_rmask got=%h exp=0", imem_rmask); end
        n_checks++; if (iq_enqueue !== 1'b0) begin n_fail++; $display("FAIL arst_enq got=%b exp=0", iq_enqueue); end
        n_checks++; if (imem_addr !== RST_PC) begin n_fail++; $display("FAIL arst_addr got=%h exp=%h", imem_addr, RST_PC); end
        n_checks++; if (iq_wdata !== 64'h0) begin n_fail++; $display("FAIL arst_wdata got=%h exp=0", iq_wdata); end
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, '0);
            n_checks++; if (o_rmask !== e_rmask) begin n_fail++; $display("FAIL arst_post_rmask k=%0d got=%h exp=%h", k, o_rmask, e_rmask); end
            n_checks++; if (o_enq !== e_enq) begin n_fail++; $display("FAIL arst_post_enq k=%0d got=%b exp=%b", k, o_enq, e_enq); end
            if (e_enq) begin n_checks++; if (o_wdata !== e_wdata) begin n_fail++; $display("FAIL arst_post_wdata k=%0d got=%h exp=%h", k, o_wdata, e_wdata); end end
            if (k == 0) first_addr = o_addr;
        end
        n_checks++; if (first_addr !== RST_PC) begin n_fail++; $display("FAIL arst_restart_addr got=%h exp=%h", first_addr, RST_PC); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full_hold();
        test_redirect();
        test_redirect_with_resp();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
